// File: rtl/conv_pe_scheduler_if.sv
// conv_pe_scheduler_if: layer-memory read port and NoC injection port of the conv PE scheduler.
interface conv_pe_scheduler_if #(
    parameter int PACKET_WIDTH  = 64,
    parameter int FILTER_LENGTH = 40
);
    logic                     mem_rd_en;
    logic                     mem_rd_sel;
    logic [4:0]               mem_rd_addr;
    logic [FILTER_LENGTH-1:0] mem_rd_data;
    logic                     pkt_valid;
    logic                     pkt_ready;
    logic [PACKET_WIDTH-1:0]  pkt_data;
    modport master (
        output mem_rd_en, mem_rd_sel, mem_rd_addr, pkt_valid, pkt_data,
        input  mem_rd_data, pkt_ready
    );
    modport slave (
        input  mem_rd_en, mem_rd_sel, mem_rd_addr, pkt_valid, pkt_data,
        output mem_rd_data, pkt_ready
    );
endinterface

// File: rtl/conv_pe_scheduler.sv
// conv_pe_scheduler: injects filter then ifmap packets into the 5-PE conv chain, pacing rows by returning psums.
module conv_pe_scheduler #(
    parameter int         PACKET_WIDTH  = 64,
    parameter int         IFMAP_LENGTH  = 25,
    parameter int         FILTER_LENGTH = 40,
    parameter int         NUM_PE        = 5,
    parameter int         NUM_ROWS      = 25,
    parameter int         CONVS_PER_ROW = 21,
    parameter logic [3:0] SRC_ADDR      = 4'b1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                psum_valid_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    conv_pe_scheduler_if.master bus
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] F_RD      = 3'd1;
    localparam logic [2:0] F_SEND    = 3'd2;
    localparam logic [2:0] I_RD      = 3'd3;
    localparam logic [2:0] I_SEND    = 3'd4;
    localparam logic [2:0] WAIT_PSUM = 3'd5;
    localparam logic [2:0] DONE      = 3'd6;
    localparam logic [2:0] LAST_IDX  = 3'(NUM_PE - 1);
    localparam logic [4:0] NPE       = 5'(NUM_PE);
    localparam logic [4:0] ROWS      = 5'(NUM_ROWS);
    localparam logic [4:0] CPR       = 5'(CONVS_PER_ROW);

    function automatic logic [3:0] pe_addr(input logic [2:0] i);
        return i == 3'd0 ? 4'b0001 : i == 3'd1 ? 4'b0101 : i == 3'd2 ? 4'b0011 :
               i == 3'd3 ? 4'b0111 : 4'b1100;
    endfunction

    logic [2:0]               state_q, state_d, idx_q, idx_d;
    logic [4:0]               row_q, row_d, psum_cnt_q, psum_cnt_d;
    logic                     err_q, err_d, fresh_q;
    logic [FILTER_LENGTH-1:0] pay_q, payload;
    logic [3:0]               dest;
    logic                     in_f, accept, cnt_full, row_done;

    assign in_f            = state_q == F_SEND;
    assign bus.pkt_valid   = in_f || state_q == I_SEND;
    assign accept          = bus.pkt_valid && bus.pkt_ready;
    assign bus.mem_rd_en   = state_q == F_RD || state_q == I_RD;
    assign bus.mem_rd_sel  = state_q == F_RD;
    assign bus.mem_rd_addr = state_q == F_RD ? {2'b00, idx_q} : state_q == I_RD ? row_q : '0;
    // Read data is only valid the cycle after the strobe; a stalled packet replays the held copy.
    assign payload         = fresh_q ? bus.mem_rd_data : pay_q;
    assign dest            = in_f ? pe_addr(idx_q) : row_q < NPE ? pe_addr(row_q[2:0]) : pe_addr(LAST_IDX);
    assign bus.pkt_data    = !bus.pkt_valid ? '0 :
                             in_f ? {dest, SRC_ADDR, 2'b01, {(PACKET_WIDTH-10-FILTER_LENGTH){1'b0}}, payload} :
                                    {dest, SRC_ADDR, 2'b00, {(PACKET_WIDTH-10-IFMAP_LENGTH){1'b0}},
                                     payload[IFMAP_LENGTH-1:0]};
    assign busy_o          = state_q != IDLE;
    assign done_o          = state_q == DONE;
    assign err_o           = err_q;

    assign cnt_full = psum_cnt_q == CPR;
    assign row_done = state_q == WAIT_PSUM && cnt_full;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        row_d   = row_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d = F_RD;
                idx_d   = '0;
                row_d   = '0;
            end
            F_RD:   state_d = F_SEND;
            F_SEND: if (accept) begin
                state_d = idx_q == LAST_IDX ? I_RD : F_RD;
                idx_d   = idx_q == LAST_IDX ? 3'd0 : idx_q + 3'd1;
            end
            I_RD:   state_d = I_SEND;
            I_SEND: if (accept) begin
                row_d   = row_q + 5'd1;
                state_d = row_q + 5'd1 < NPE ? I_RD : WAIT_PSUM;
            end
            WAIT_PSUM: if (cnt_full) state_d = row_q == ROWS ? DONE : I_RD;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counter saturates at a full row; an overflowing psum (or any psum while idle) is a protocol error.
    assign psum_cnt_d = state_q == IDLE ? (start_i ? 5'd0 : psum_cnt_q) :
                        row_done ? {4'b0, psum_valid_i} :
                        psum_valid_i && !cnt_full ? psum_cnt_q + 5'd1 : psum_cnt_q;
    assign err_d      = state_q == IDLE && start_i ? 1'b0 :
                        err_q | (psum_valid_i && (state_q == IDLE || (cnt_full && !row_done)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            row_q      <= '0;
            psum_cnt_q <= '0;
            err_q      <= 1'b0;
            fresh_q    <= 1'b0;
            pay_q      <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            row_q      <= row_d;
            psum_cnt_q <= psum_cnt_d;
            err_q      <= err_d;
            fresh_q    <= bus.mem_rd_en;
            pay_q      <= payload;
        end
    end
endmodule

// File: tb/tb_conv_pe_scheduler.sv
// tb_conv_pe_scheduler: randomized layer runs of conv_pe_scheduler against a packet-list reference model.
module tb_conv_pe_scheduler;
    logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, psum_valid_i = 1'b0;
    logic busy_o, done_o, err_o;
    int   n_cmp = 0, n_err = 0;

    conv_pe_scheduler_if bus ();
    conv_pe_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .psum_valid_i(psum_valid_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [3:0]  pe_tab [5] = '{4'b0001, 4'b0101, 4'b0011, 4'b0111, 4'b1100};
    logic [39:0] filt [32];
    logic [24:0] ifm [32];
    logic [63:0] acc_q [$];
    int          rd_cnt = 0, done_cnt = 0, ifm_acc = 0, psum_pend = 0, psum_wait = 0;
    bit          auto_psum = 1'b0, psum_man = 1'b0, gen;
    logic        rd_en_s = 1'b0, rd_sel_s = 1'b0;
    logic [4:0]  rd_addr_s = '0;

    // Reference: the full layer is 5 filter packets then 25 ifmap rows, in order.
    function automatic logic [63:0] exp_pkt(input int k);
        int r;
        if (k < 5) return {pe_tab[k], 4'b1000, 2'b01, 14'b0, filt[k]};
        r = k - 5;
        return {pe_tab[r < 5 ? r : 4], 4'b1000, 2'b00, 29'b0, ifm[r]};
    endfunction

    // Monitor, psum responder (21 psums ~10 cycles after each row that completes an output row).
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            psum_pend = 0; psum_wait = 0; ifm_acc = 0;
        end else begin
            if (bus.pkt_valid && bus.pkt_ready) begin
                acc_q.push_back(bus.pkt_data);
                if (bus.pkt_data[55:54] == 2'b00) begin
                    ifm_acc++;
                    if (ifm_acc >= 5) begin
                        if (psum_pend == 0) psum_wait = 10;
                        psum_pend += 21;
                    end
                end
            end
            if (bus.mem_rd_en) rd_cnt++;
            if (done_o) done_cnt++;
        end
        rd_en_s = bus.mem_rd_en; rd_sel_s = bus.mem_rd_sel; rd_addr_s = bus.mem_rd_addr;
        if (auto_psum) begin
            if (psum_wait > 0) begin gen = 1'b0; psum_wait--; end
            else if (psum_pend > 0) begin gen = 1'($urandom_range(0, 1)); if (gen) psum_pend--; end
            else gen = 1'b0;
            psum_valid_i = gen;
        end else psum_valid_i = psum_man;
    end

    // Layer memory: data valid exactly one cycle after the strobe, garbage otherwise.
    initial forever begin
        @(posedge clk); #1;
        bus.mem_rd_data = rd_en_s ? (rd_sel_s ? filt[rd_addr_s] : {15'b0, ifm[rd_addr_s]})
                                  : 40'({$urandom, $urandom});
    end

    task automatic apply_reset;
        rst_n = 1'b0; start_i = 1'b0; psum_man = 1'b0; auto_psum = 1'b0; bus.pkt_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        acc_q.delete(); rd_cnt = 0; done_cnt = 0;
        for (int r = 0; r < 25; r++) ifm[r] = 25'($urandom);
    endtask

    task automatic pulse_start;
        @(posedge clk); #1 start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit to);
        to = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk); #1;
            if (done_cnt > 0) begin to = 1'b0; break; end
        end
    endtask

    task automatic wait_acc(input int n, input int budget, output bit to);
        to = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk); #1;
            if (acc_q.size() >= n) begin to = 1'b0; break; end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; bus.pkt_ready = 1'b1;
        repeat (2) @(negedge clk); #1;
        n_cmp++;
        if ({busy_o, done_o, err_o, bus.pkt_valid, bus.mem_rd_en} !== 5'b0) begin
            n_err++; $display("FAIL reset_outs: got %b want 00000", {busy_o, done_o, err_o, bus.pkt_valid, bus.mem_rd_en});
        end
        n_cmp++;
        if (bus.pkt_data !== 64'd0 || bus.mem_rd_addr !== 5'd0) begin
            n_err++; $display("FAIL reset_data: got %h/%h want 0/0", bus.pkt_data, bus.mem_rd_addr);
        end
        apply_reset;
        repeat (3) @(negedge clk); #1;
        n_cmp++;
        if ({busy_o, bus.pkt_valid, bus.mem_rd_en} !== 3'b0) begin
            n_err++; $display("FAIL idle_no_start: got %b want 000", {busy_o, bus.pkt_valid, bus.mem_rd_en});
        end
    endtask

    task automatic test_full_layer;
        bit to;
        apply_reset; auto_psum = 1'b1;
        pulse_start;
        wait_done(5000, to);
        repeat (3) @(negedge clk); #1;
        n_cmp++;
        if (to !== 1'b0) begin n_err++; $display("FAIL layer_timeout: got timeout=%b want 0", to); end
        n_cmp++;
        if (acc_q.size() !== 30) begin n_err++; $display("FAIL layer_pkt_count: got %0d want 30", acc_q.size()); end
        for (int k = 0; k < 30 && k < acc_q.size(); k++) begin
            n_cmp++;
            if (acc_q[k] !== exp_pkt(k)) begin
                n_err++; $display("FAIL layer_pkt%0d: got %h want %h", k, acc_q[k], exp_pkt(k));
            end
        end
        n_cmp++;
        if (done_cnt !== 1) begin n_err++; $display("FAIL done_pulses: got %0d want 1", done_cnt); end
        n_cmp++;
        if ({err_o, busy_o} !== 2'b00) begin n_err++; $display("FAIL layer_end_err_busy: got %b want 00", {err_o, busy_o}); end
        n_cmp++;
        if (rd_cnt !== 30) begin n_err++; $display("FAIL layer_reads: got %0d want 30", rd_cnt); end
    endtask

    task automatic test_stall;
        bit to;
        int snap, bad;
        apply_reset; auto_psum = 1'b1;
        pulse_start;
        wait_acc(2, 50, to);
        @(posedge clk); #1 bus.pkt_ready = 1'b0;
        @(negedge clk); #1 snap = rd_cnt;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk); #1;
            n_cmp++;
            if (bus.pkt_valid !== 1'b1 || bus.pkt_data !== exp_pkt(2)) begin
                n_err++; $display("FAIL stall_hold c%0d: got v=%b %h want v=1 %h", c, bus.pkt_valid, bus.pkt_data, exp_pkt(2));
            end
        end
        n_cmp++;
        if (rd_cnt !== snap) begin n_err++; $display("FAIL stall_reads: got %0d want %0d", rd_cnt, snap); end
        @(posedge clk); #1 bus.pkt_ready = 1'b1;
        wait_done(5000, to);
        bad = 0;
        for (int k = 0; k < acc_q.size(); k++) if (k >= 30 || acc_q[k] !== exp_pkt(k)) bad++;
        n_cmp++;
        if (to !== 1'b0 || acc_q.size() !== 30 || bad !== 0) begin
            n_err++; $display("FAIL stall_resume: got to=%b n=%0d bad=%0d want 0/30/0", to, acc_q.size(), bad);
        end
        n_cmp++;
        if (rd_cnt !== 30) begin n_err++; $display("FAIL stall_total_reads: got %0d want 30", rd_cnt); end
    endtask

    task automatic test_psum_pace;
        bit to;
        int snap, k;
        apply_reset;
        pulse_start;
        wait_acc(10, 100, to);
        repeat (3) @(negedge clk); #1 snap = rd_cnt;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1 psum_man = 1'b1;
            @(posedge clk); #1 psum_man = 1'b0;
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        repeat (5) @(negedge clk); #1;
        n_cmp++;
        if (to !== 1'b0 || rd_cnt !== snap || acc_q.size() !== 10 || busy_o !== 1'b1) begin
            n_err++; $display("FAIL pace_20_psums: got to=%b reads=%0d pkts=%0d busy=%b want 0/%0d/10/1", to, rd_cnt, acc_q.size(), busy_o, snap);
        end
        @(posedge clk); #1 psum_man = 1'b1;
        @(posedge clk); #1 psum_man = 1'b0;
        k = 9;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            if (bus.mem_rd_en) begin k = c; break; end
        end
        n_cmp++;
        if (k > 1 || bus.mem_rd_sel !== 1'b0 || bus.mem_rd_addr !== 5'd5) begin
            n_err++; $display("FAIL pace_21st_read: got delay=%0d sel=%b addr=%0d want <=1/0/5", k, bus.mem_rd_sel, bus.mem_rd_addr);
        end
        wait_acc(11, 20, to);
        n_cmp++;
        if (to !== 1'b0 || acc_q[10] !== exp_pkt(10) || acc_q[10][63:60] !== 4'b1100) begin
            n_err++; $display("FAIL pace_row5_pkt: got %h want %h", to ? 64'hx : acc_q[10], exp_pkt(10));
        end
        n_cmp++;
        if (err_o !== 1'b0) begin n_err++; $display("FAIL pace_err: got %b want 0", err_o); end
    endtask

    task automatic test_idle_psum;
        apply_reset;
        @(posedge clk); #1 psum_man = 1'b1;
        @(posedge clk); #1 psum_man = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if ({err_o, busy_o} !== 2'b10) begin n_err++; $display("FAIL idle_psum_err: got %b want 10", {err_o, busy_o}); end
        repeat (5) @(negedge clk); #1;
        n_cmp++;
        if (err_o !== 1'b1 || acc_q.size() !== 0 || bus.pkt_valid !== 1'b0) begin
            n_err++; $display("FAIL idle_err_sticky: got err=%b pkts=%0d v=%b want 1/0/0", err_o, acc_q.size(), bus.pkt_valid);
        end
        pulse_start;
        @(negedge clk); #1;
        n_cmp++;
        if ({err_o, busy_o} !== 2'b01) begin n_err++; $display("FAIL start_clears_err: got %b want 01", {err_o, busy_o}); end
        pulse_start;
        repeat (4) @(negedge clk); #1;
        n_cmp++;
        if (err_o !== 1'b0) begin n_err++; $display("FAIL start_while_busy_err: got %b want 0", err_o); end
    endtask

    task automatic test_midreset;
        bit to, tv;
        apply_reset; auto_psum = 1'b1;
        pulse_start;
        wait_acc(17, 3000, to);
        @(posedge clk); #1 bus.pkt_ready = 1'b0;
        tv = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk); #1;
            if (bus.pkt_valid) begin tv = 1'b0; break; end
        end
        n_cmp++;
        if (to !== 1'b0 || tv !== 1'b0 || bus.pkt_data !== exp_pkt(17)) begin
            n_err++; $display("FAIL midrst_row12_pkt: got to=%b/%b %h want %h", to, tv, bus.pkt_data, exp_pkt(17));
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.pkt_valid, busy_o} !== 2'b00) begin
            n_err++; $display("FAIL midrst_outs: got %b want 00", {bus.pkt_valid, busy_o});
        end
        @(negedge clk); #2 rst_n = 1'b1;
        bus.pkt_ready = 1'b1; acc_q.delete();
        pulse_start;
        wait_acc(1, 20, to);
        n_cmp++;
        if (to !== 1'b0 || acc_q[0] !== exp_pkt(0)) begin
            n_err++; $display("FAIL midrst_restart: got %h want %h", to ? 64'hx : acc_q[0], exp_pkt(0));
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            filt[i] = i < 5 ? {5{8'(i)}} : 40'd0;
            ifm[i]  = '0;
        end
        bus.pkt_ready = 1'b1;
        bus.mem_rd_data = '0;
        test_reset;
        test_full_layer;
        test_stall;
        test_psum_pace;
        test_idle_psum;
        test_midreset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
